multicycle_controller: RTL and testbench

- Multi-cycle sequencing FSM for the RV32I core; drives the shared ALU, register file, PC and the single unified memory port across FETCH/DECODE/EXECUTE/MEM/WB.
- Decodes add, sub, addi, lw, sw and beq from the latched instruction.
- Owns the memory req/ready handshake, with a timeout.
- Halts on an illegal opcode or a memory timeout.

---
 rtl/core_pkg.sv | 16 +
 rtl/multicycle_controller.sv | 103 ++++++++++
 tb/tb_multicycle_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: opcode and ALU encodings, controller state type and the legality check for the
// RV32I subset (add, sub, addi, lw, sw, beq) executed by multicycle_controller.
package core_pkg;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT} ctrl_state_t;
  function automatic logic decode_legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    return (op == OPC_RTYPE) ? (f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000))
                             : (op inside {OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH});
  endfunction
endpackage

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEM/WB sequencer with a timed memory handshake.
// Define MULTICYCLE_RETIRE_CNT_EN to add the retire_count output.
module multicycle_controller
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        alu_src,
  output logic [3:0]  alu_control,
  output logic        halted,
  output logic        illegal,
`ifdef MULTICYCLE_RETIRE_CNT_EN
  output logic [31:0] retire_count,
`endif
  output logic        bus_error
);
  ctrl_state_t state;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [TO_W-1:0] cnt;
  logic is_r, is_ld, is_st, is_br, waiting, limit, alu_on;
  assign is_r = opcode == OPC_RTYPE;
  assign is_ld = opcode == OPC_LOAD;
  assign is_st = opcode == OPC_STORE;
  assign is_br = opcode == OPC_BRANCH;
  assign waiting = state == FETCH || state == MEM;
  assign limit = MEM_TIMEOUT != 0 && cnt == TO_W'(MEM_TIMEOUT - 1);
  // ALU operands stay at the EXECUTE setting through MEM and WB so the address/result is stable
  assign alu_on = state == EXECUTE || state == MEM || state == WB;
  assign mem_req = waiting;
  assign mem_we = state == MEM && is_st;
  assign mem_addr_sel = state == MEM;
  assign ir_we = state == FETCH && mem_ready;
  assign pc_we = ir_we || (state == EXECUTE && is_br && alu_zero);
  assign pc_src = state == EXECUTE && is_br;
  assign reg_write = state == WB;
  assign wb_sel = state == WB && is_ld;
  assign alu_src = alu_on && !is_r && !is_br;
  assign alu_control = !alu_on ? 4'b0000 : (is_br || (is_r && funct7[5])) ? ALU_SUB : ALU_ADD;
  assign halted = state == HALT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      opcode <= '0;
      funct3 <= '0;
      funct7 <= '0;
      cnt <= '0;
      illegal <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      cnt <= (waiting && !mem_ready) ? cnt + 1'b1 : '0;
      case (state)
        IDLE: state <= FETCH;
        FETCH:
          if (mem_ready) begin
            opcode <= instr[6:0];
            funct3 <= instr[14:12];
            funct7 <= instr[31:25];
            state <= DECODE;
          end else if (limit) begin
            state <= HALT;
            bus_error <= 1'b1;
          end
        DECODE:
          if (decode_legal(opcode, funct3, funct7)) state <= EXECUTE;
          else begin
            state <= HALT;
            illegal <= 1'b1;
          end
        EXECUTE: state <= (is_ld || is_st) ? MEM : is_br ? FETCH : WB;
        MEM:
          if (mem_ready) state <= is_ld ? WB : FETCH;
          else if (limit) begin
            state <= HALT;
            bus_error <= 1'b1;
          end
        WB: state <= FETCH;
        default: state <= HALT;
      endcase
    end
  end
`ifdef MULTICYCLE_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_count <= '0;
    else if (state == WB || (state == MEM && is_st && mem_ready) || (state == EXECUTE && is_br))
      retire_count <= retire_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-cycle scoreboard of stimulus and expected control outputs.
module tb_multicycle_controller;
  logic clk = 1'b0, rst = 1'b1, alu_zero = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = '0;
  logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_write, wb_sel, alu_src;
  logic halted, illegal, bus_error;
  logic [3:0] alu_control;
`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif
  int cmp = 0, bad = 0;
  multicycle_controller #(.MEM_TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src(alu_src), .alu_control(alu_control), .halted(halted), .illegal(illegal),
`ifdef MULTICYCLE_RETIRE_CNT_EN
    .retire_count(retire_count),
`endif
    .bus_error(bus_error));
  always #5 clk = ~clk;
  wire [15:0] outs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_write, wb_sel,
                      alu_src, alu_control, halted, illegal, bus_error};
  localparam logic [15:0] REQ = 16'h8000, WE = 16'h4000, ASEL = 16'h2000, IRW = 16'h1000;
  localparam logic [15:0] PCW = 16'h0800, PCS = 16'h0400, RW = 16'h0200, WBS = 16'h0100;
  localparam logic [15:0] ASRC = 16'h0080, ADD = 16'h0010, SUB = 16'h0030;
  localparam logic [15:0] H = 16'h0004, IL = 16'h0002, BE = 16'h0001;
  localparam logic [15:0] FW = REQ, FR = REQ | IRW | PCW, EXI = ASRC | ADD, MEMI = REQ | ASEL | ASRC | ADD;
  localparam logic [31:0] I_ADD = 32'h002081B3, I_SUB = 32'h402081B3, I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW = 32'h0040A283, I_SW = 32'h0020A423, I_BEQ = 32'h00208463;
  localparam logic [31:0] I_BAD = 32'h0000007F, I_MUL = 32'h022081B3;
  typedef struct {
    logic r, rdy, z;
    logic [31:0] ins;
    logic [15:0] v;
  } ent_t;
  ent_t sb[$];
  ent_t e;
  task automatic push(input logic r, input logic rdy, input logic z, input logic [31:0] ins, input logic [15:0] v);
    sb.push_back('{r, rdy, z, ins, v});
  endtask
  task automatic start(input logic [31:0] ins);
    push(1, 0, 0, ins, 0);
    push(0, 0, 0, ins, 0);
    push(0, 1, 0, ins, FR);
    push(0, 1, 0, ins, 0);
  endtask
  task automatic test_reset();
    push(1, 1, 0, 0, 0);
    push(1, 1, 0, 0, 0);
    push(0, 1, 0, 0, 0);
    push(0, 0, 0, 0, FW);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL reset[%0d] outs=%h expected=%h", i, outs, e.v); end
`ifdef MULTICYCLE_RETIRE_CNT_EN
      cmp++;
      if (e.r && retire_count !== 0) begin bad++; $display("FAIL reset_retire[%0d] got=%0d expected=0", i, retire_count); end
`endif
      @(posedge clk); #1;
    end
  endtask
  task automatic test_add();
    start(I_ADD);
    push(0, 1, 0, I_ADD, ADD);
    push(0, 1, 0, I_ADD, RW | ADD);
    push(0, 0, 0, I_ADD, FW);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL add[%0d] outs=%h expected=%h", i, outs, e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back();
    start(I_SUB);
    push(0, 1, 0, I_SUB, SUB);
    push(0, 1, 0, I_SUB, RW | SUB);
    push(0, 1, 0, I_ADDI, FR);
    push(0, 1, 0, I_ADDI, 0);
    push(0, 1, 0, I_ADDI, EXI);
    push(0, 1, 0, I_ADDI, RW | EXI);
    push(0, 0, 0, I_ADDI, FW);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL b2b[%0d] outs=%h expected=%h", i, outs, e.v); end
      @(posedge clk); #1;
    end
`ifdef MULTICYCLE_RETIRE_CNT_EN
    cmp++;
    if (retire_count !== 32'd2) begin bad++; $display("FAIL b2b_retire got=%0d expected=2", retire_count); end
`endif
  endtask
  task automatic test_lw_wait();
    start(I_LW);
    push(0, 1, 0, I_LW, EXI);
    for (int k = 0; k < 3; k++) push(0, 0, 0, I_LW, MEMI);
    push(0, 1, 0, I_LW, MEMI);
    push(0, 1, 0, I_LW, RW | WBS | EXI);
    push(0, 0, 0, I_LW, FW);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL lw[%0d] outs=%h expected=%h", i, outs, e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_sw();
    start(I_SW);
    push(0, 1, 0, I_SW, EXI);
    push(0, 1, 0, I_SW, MEMI | WE);
    push(0, 0, 0, I_SW, FW);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL sw[%0d] outs=%h expected=%h", i, outs, e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_beq();
    start(I_BEQ);
    push(0, 1, 1, I_BEQ, SUB | PCS | PCW);
    push(0, 1, 0, I_BEQ, FR);
    push(0, 1, 1, I_BEQ, 0);
    push(0, 1, 0, I_BEQ, SUB | PCS);
    push(0, 0, 1, I_BEQ, FW);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL beq[%0d] outs=%h expected=%h", i, outs, e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_illegal();
    start(I_BAD);
    push(0, 1, 0, I_BAD, H | IL);
    push(0, 1, 0, I_ADD, H | IL);
    start(I_MUL);
    push(0, 1, 0, I_MUL, H | IL);
    push(0, 1, 0, I_ADD, H | IL);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL illegal[%0d] outs=%h expected=%h", i, outs, e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_timeout();
    push(1, 0, 0, I_ADD, 0);
    push(0, 0, 0, I_ADD, 0);
    for (int k = 0; k < 4; k++) push(0, 0, 0, I_ADD, FW);
    push(0, 1, 0, I_ADD, H | BE);
    push(0, 1, 0, I_ADD, H | BE);
    push(1, 0, 0, I_ADD, 0);
    push(0, 0, 0, I_ADD, 0);
    for (int k = 0; k < 3; k++) push(0, 0, 0, I_ADD, FW);
    push(0, 1, 0, I_ADD, FR);
    push(0, 1, 0, I_ADD, 0);
    push(0, 1, 0, I_ADD, ADD);
    push(0, 1, 0, I_ADD, RW | ADD);
    start(I_LW);
    push(0, 0, 0, I_LW, EXI);
    for (int k = 0; k < 4; k++) push(0, 0, 0, I_LW, MEMI);
    push(0, 1, 0, I_LW, H | BE);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL timeout[%0d] outs=%h expected=%h", i, outs, e.v); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_rst_mid();
    start(I_SW);
    push(0, 0, 0, I_SW, EXI);
    push(0, 0, 0, I_SW, MEMI | WE);
    push(1, 0, 0, I_SW, 0);
    push(0, 1, 0, I_SW, 0);
    push(0, 0, 0, I_SW, FW);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      rst = e.r; mem_ready = e.rdy; alu_zero = e.z; instr = e.ins;
      @(negedge clk);
      cmp++;
      if (outs !== e.v) begin bad++; $display("FAIL rst_mid[%0d] outs=%h expected=%h", i, outs, e.v); end
`ifdef MULTICYCLE_RETIRE_CNT_EN
      cmp++;
      if (e.r && retire_count !== 0) begin bad++; $display("FAIL rst_mid_retire got=%0d expected=0", retire_count); end
`endif
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_lw_wait();
    test_sw();
    test_beq();
    test_illegal();
    test_reset();
    test_timeout();
    test_reset();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired compared=%0d", cmp);
    $fatal(1, "watchdog");
  end
endmodule
